// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MIPS memory stage: FSM states,
// the M/WB register layout and the word-alignment rule.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ABORT
    } mem_state_e;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        memtoreg;
        logic        regwrite;
    } m_wb_t;

    localparam m_wb_t      M_WB_BUBBLE = '0;
    localparam logic [1:0] ALIGN_MASK  = 2'b11;

    function automatic logic is_misaligned(input logic access, input logic [1:0] addr_lsb);
        return access && ((addr_lsb & ALIGN_MASK) != 2'b00);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts request cycles of an outstanding memory access; expired_o flags the
// cycle in which the count reaches TIMEOUT so the FSM can abort instead.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int                CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    // A non-zero count keeps advancing on its own and saturates at LIMIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear_i) begin
            wait_cnt_d = '0;
        end else if (start_i) begin
            wait_cnt_d = CNT_W'(1);
        end else if (wait_cnt_q != '0 && wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = !clear_i && (wait_cnt_d == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS memory-stage controller: issues loads/stores over req/ack, stalls the
// front of the pipeline while waiting, aborts on timeout and drives M/WB.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_M_result,
    input  logic [31:0] EX_M_write_data,
    input  logic [4:0]  EX_M_rd,
    input  logic        EX_M_memread,
    input  logic        EX_M_memwrite,
    input  logic        EX_M_memtoreg,
    input  logic        EX_M_regwrite,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] M_WB_read_data,
    output logic [31:0] M_WB_result,
    output logic [4:0]  M_WB_rd,
    output logic        M_WB_memtoreg,
    output logic        M_WB_regwrite,
    output logic        align_err,
    output logic        timeout_err
);

    mem_state_e state_q, state_d;
    m_wb_t      mwb_q, mwb_d;
    logic       align_err_q, align_err_d;
    logic       timeout_err_q, timeout_err_d;

    logic access;
    logic misaligned;
    logic abort;
    logic timer_start;
    logic timer_clear;
    logic timer_expired;

    assign access     = EX_M_memread | EX_M_memwrite;
    assign misaligned = is_misaligned(access, EX_M_result[1:0]);

    assign mem_req   = !rst && ((state_q == ST_IDLE && access && !misaligned) || state_q == ST_BUSY);
    assign mem_we    = mem_req && EX_M_memwrite;
    assign mem_addr  = EX_M_result;
    assign mem_wdata = EX_M_write_data;
    assign stall     = mem_req && !mem_ack;

    assign timer_start = (state_q == ST_IDLE) && mem_req && !mem_ack;
    assign timer_clear = (state_q == ST_BUSY && mem_ack) || state_q == ST_ABORT;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .start_i   (timer_start),
        .clear_i   (timer_clear),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req && !mem_ack) begin
                    state_d = timer_expired ? ST_ABORT : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end else if (timer_expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                abort   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Anything other than a stall, abort or misaligned access forwards EX/M;
    // read data is only taken from memory when a load completes this cycle.
    always_comb begin
        mwb_d = M_WB_BUBBLE;
        if (!stall && !abort && !misaligned) begin
            mwb_d.result   = EX_M_result;
            mwb_d.rd       = EX_M_rd;
            mwb_d.memtoreg = EX_M_memtoreg;
            mwb_d.regwrite = EX_M_regwrite;
            if (mem_req && mem_ack && !EX_M_memwrite) begin
                mwb_d.read_data = mem_rdata;
            end
        end
        align_err_d   = align_err_q | (state_q == ST_IDLE && misaligned);
        timeout_err_d = timeout_err_q | abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mwb_q         <= M_WB_BUBBLE;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mwb_q         <= mwb_d;
            align_err_q   <= align_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign M_WB_read_data = mwb_q.read_data;
    assign M_WB_result    = mwb_q.result;
    assign M_WB_rd        = mwb_q.rd;
    assign M_WB_memtoreg  = mwb_q.memtoreg;
    assign M_WB_regwrite  = mwb_q.regwrite;
    assign align_err      = align_err_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus random
// instruction streams, checked cycle by cycle against a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] EX_M_result, EX_M_write_data;
    logic [4:0]  EX_M_rd;
    logic        EX_M_memread, EX_M_memwrite, EX_M_memtoreg, EX_M_regwrite;
    logic        mem_req, mem_we, mem_ack, stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] M_WB_read_data, M_WB_result;
    logic [4:0]  M_WB_rd;
    logic        M_WB_memtoreg, M_WB_regwrite, align_err, timeout_err;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .EX_M_result     (EX_M_result),
        .EX_M_write_data (EX_M_write_data),
        .EX_M_rd         (EX_M_rd),
        .EX_M_memread    (EX_M_memread),
        .EX_M_memwrite   (EX_M_memwrite),
        .EX_M_memtoreg   (EX_M_memtoreg),
        .EX_M_regwrite   (EX_M_regwrite),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .stall           (stall),
        .M_WB_read_data  (M_WB_read_data),
        .M_WB_result     (M_WB_result),
        .M_WB_rd         (M_WB_rd),
        .M_WB_memtoreg   (M_WB_memtoreg),
        .M_WB_regwrite   (M_WB_regwrite),
        .align_err       (align_err),
        .timeout_err     (timeout_err)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;
    logic exp_align = 1'b0;
    logic exp_tmo   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_comb(input logic e_req, input logic e_stall, input logic e_we,
                              input logic [31:0] e_addr, input logic [31:0] e_wdata);
        check("mem_req", 32'(mem_req), 32'(e_req));
        check("stall", 32'(stall), 32'(e_stall));
        if (e_req) begin
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
        end
    endtask

    task automatic check_mwb(input logic [31:0] e_rdata, input logic [31:0] e_res,
                             input logic [4:0] e_rd, input logic e_mtr, input logic e_rw);
        check("M_WB_read_data", M_WB_read_data, e_rdata);
        check("M_WB_result", M_WB_result, e_res);
        check("M_WB_ctrl", {25'b0, M_WB_rd, M_WB_memtoreg, M_WB_regwrite}, {25'b0, e_rd, e_mtr, e_rw});
        check("align_err", 32'(align_err), 32'(exp_align));
        check("timeout_err", 32'(timeout_err), 32'(exp_tmo));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic mtr, input logic rw);
        EX_M_result = res; EX_M_write_data = wd; EX_M_rd = rd;
        EX_M_memread = mr; EX_M_memwrite = mw; EX_M_memtoreg = mtr; EX_M_regwrite = rw;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        tick();
        exp_align = 1'b0;
        exp_tmo   = 1'b0;
        check_mwb(32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // lat = request cycle in which ack arrives; lat > TO means no ack (timeout).
    task automatic run_instr(input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd,
                             input logic mr, input logic mw, input logic mtr, input logic rw,
                             input int lat, input logic [31:0] ack_data);
        logic access, mis;
        access = mr | mw;
        mis    = access && (res[1:0] != 2'b00);
        drive(res, wd, rd, mr, mw, mtr, rw);
        n_txn++;
        $display("txn %0d: addr=0x%08h rd=%0d memread=%0b memwrite=%0b lat=%0d", n_txn, res, rd, mr, mw, lat);
        if (!access || mis) begin
            mem_ack = 1'($urandom);
            mem_rdata = $urandom;
            #1;
            check_comb(1'b0, 1'b0, 1'b0, res, wd);
            tick();
            exp_align = exp_align | mis;
            if (mis) check_mwb(32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
            else     check_mwb(32'd0, res, rd, mtr, rw);
        end else if (lat <= TO) begin
            for (int c = 1; c <= lat; c++) begin
                mem_ack   = (c == lat);
                mem_rdata = (c == lat) ? ack_data : $urandom;
                #1;
                check_comb(1'b1, c < lat, mw, res, wd);
                tick();
                if (c < lat) check_mwb(32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
                else         check_mwb(mw ? 32'd0 : ack_data, res, rd, mtr, rw);
            end
        end else begin
            for (int c = 1; c <= TO; c++) begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                #1;
                check_comb(1'b1, 1'b1, mw, res, wd);
                tick();
                check_mwb(32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
            end
            mem_ack = 1'($urandom);
            mem_rdata = $urandom;
            #1;
            check_comb(1'b0, 1'b0, 1'b0, res, wd);
            tick();
            exp_tmo = 1'b1;
            check_mwb(32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset_dut();

        // Zero-wait load, then back-to-back zero-wait loads
        run_instr(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'hDEADBEEF);
        run_instr(32'h14, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h11112222);
        run_instr(32'h18, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h33334444);
        // Store acked in request cycle 3, and one acked exactly at TIMEOUT
        run_instr(32'h20, 32'h1234, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 32'hCAFEF00D);
        run_instr(32'h24, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, TO, 32'h0BADF00D);
        // Misaligned load followed by a plain add
        run_instr(32'h13, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h55555555);
        run_instr(32'h0000ABCD, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
        // Timeout on a load with no ack
        run_instr(32'h40, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, TO + 1, 32'h0);

        // Reset in the second wait cycle of a load, then a normal load
        drive(32'h80, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
        mem_ack = 1'b0;
        #1;
        check_comb(1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
        tick();
        check_mwb(32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        reset_dut();
        run_instr(32'h84, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 2, 32'hA5A5A5A5);

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            logic [31:0] addr;
            logic        mr, mw;
            int          kind;
            kind = int'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
            mr = (kind == 1) || (kind == 3);
            mw = (kind == 2) || (kind == 3);
            run_instr(addr, $urandom, 5'($urandom), mr, mw, 1'($urandom), 1'($urandom),
                      int'($urandom_range(1, TO + 1)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller for the 5-stage MIPS pipeline: consumes the EX/M pipeline register outputs and performs the load/store against a data memory over a req/ack handshake. It holds the pipeline with `stall` while an access is outstanding, aborts accesses that exceed a timeout, and drives the M/WB pipeline register. It sits between the EX/M register and the write-back stage.

## Interface
- `TIMEOUT`, 16: number of request cycles without `mem_ack` before abort; must be ≥1.
- `clk` in 1: pipeline clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `EX_M_result` in 32: ALU result; the memory byte address for loads and stores.
- `EX_M_write_data` in 32: store data.
- `EX_M_rd` in 5: destination register.
- `EX_M_memread`, `EX_M_memwrite`, `EX_M_memtoreg`, `EX_M_regwrite` in 1 each: control bits from EX/M.
- `mem_req` out 1: access request (combinational).
- `mem_we` out 1: 1 = write; valid while `mem_req`.
- `mem_addr` out 32: equals `EX_M_result`.
- `mem_wdata` out 32: equals `EX_M_write_data`.
- `mem_ack` in 1: access complete; sampled only while `mem_req`=1.
- `mem_rdata` in 32: load data; valid with `mem_ack`.
- `stall` out 1: freeze PC, IF/ID, ID/EX, EX/M (combinational).
- `M_WB_read_data`, `M_WB_result` out 32; `M_WB_rd` out 5; `M_WB_memtoreg`, `M_WB_regwrite` out 1: M/WB register.
- `align_err`, `timeout_err` out 1: sticky error flags, cleared only by `rst`.

## Operation
- `access` = `EX_M_memread | EX_M_memwrite`. If both are set, the access is a write.
- `misaligned` = `access & (EX_M_result[1:0] != 0)`. A misaligned access issues no request. It sets `align_err`, does not stall, and loads a bubble into M/WB.
- States:
  - IDLE: if `access & !misaligned`, assert `mem_req`. With `mem_ack`, complete this cycle. Without `mem_ack`, go to BUSY with `wait_cnt`=1.
  - BUSY: hold `mem_req`. With `mem_ack`, complete and go to IDLE. Without `mem_ack`, increment `wait_cnt`. At `wait_cnt`==`TIMEOUT`, go to ABORT.
  - ABORT: this lasts one cycle. `mem_req`=0 and `stall`=0. Load a bubble into M/WB, set `timeout_err`, clear `wait_cnt`, go to IDLE.
- `stall` = `mem_req & !mem_ack`.
- M/WB loads on every posedge with `rst`=0:
  - If `stall`: load a bubble. Bubble = all M/WB fields 0.
  - Else, on a completed access: `M_WB_read_data` ← `mem_rdata` for a load, 0 for a store. Other fields ← their EX_M counterparts.
  - Else, non-memory instruction: pass the EX_M fields through, with `M_WB_read_data` ← 0.
- Inputs are stable during BUSY because `stall` freezes EX/M; the block does not re-latch them.
- `wait_cnt` width is `$clog2(TIMEOUT+1)`; it never wraps.

## Timing
- Zero-wait memory (ack in the request cycle): 0 stall cycles; data is in M/WB after the next posedge.
- N-cycle ack (ack in request cycle N ≤ `TIMEOUT`): `stall` high for N−1 cycles.
- Timeout: `mem_req` high for exactly `TIMEOUT` cycles, then 1 ABORT cycle. Total stall is `TIMEOUT` cycles. An ack during ABORT is ignored.
- Reset values: state IDLE, `wait_cnt` 0, all M/WB outputs 0, `align_err`/`timeout_err` 0.
- While `rst`=1, `mem_req` and `stall` are forced to 0.
- Reset mid-BUSY: the request drops in the reset cycle and no completion is recorded.
- Ack and `TIMEOUT` boundary: an ack in request cycle `TIMEOUT` completes normally. No abort occurs and no error is set.

## Structure
- A shared pipeline package holds:
  - the state enum (IDLE, BUSY, ABORT);
  - a `M_WB_BUBBLE` constant;
  - the `ALIGN_MASK` 2'b11 constant.
- One sub-module, `mem_wait_timer`, contains the `wait_cnt` counter:
  - inputs: start, clear, `TIMEOUT` compare;
  - output: `expired`.
- FSM, handshake and M/WB register live in `mem_stage_ctrl`.

## Test plan
- **Zero-wait load:** `lw` to addr 0x10, `mem_ack` in the same cycle with `mem_rdata`=0xDEADBEEF, rd=5.
  - -> `stall` never high.
  - -> next cycle `M_WB_read_data`=0xDEADBEEF, `M_WB_rd`=5, `M_WB_regwrite`=1, `M_WB_memtoreg`=1.
- **3-cycle store:** `sw` to 0x20, data 0x1234, ack in request cycle 3.
  - -> `mem_req`/`mem_we` high 3 cycles, `stall` high 2 cycles.
  - -> 2 bubbles, then M/WB `regwrite`=0.
- **Timeout:** `TIMEOUT`=4, load with no ack.
  - -> `mem_req` high 4 cycles.
  - -> cycle 5: `mem_req`=0, `stall`=0.
  - -> then `timeout_err`=1 and an M/WB bubble.
- **Misaligned load:** load to addr 0x13.
  - -> `mem_req`=0, `stall`=0.
  - -> `align_err`=1 next cycle, M/WB `regwrite`=0.
  - -> the following `add` passes through unaffected.
- **Reset mid-BUSY:** `rst` asserted in the 2nd wait cycle.
  - -> `mem_req`=0 the same cycle.
  - -> all outputs 0 after the edge; the next load proceeds normally.
- **Back-to-back:** load followed by load, both zero-wait.
  - -> M/WB shows both results on consecutive cycles with no bubble.
